sdm_serial_tx7: RTL and testbench
=================================

Name: sdm_serial_tx7

Overview:
- Parallel-to-serial transmitter for 7-bit words; the sending end of the 7-bit serial link whose receiving end deserialises into a 7-bit parallel register.
- Accepts one word over a valid/ready handshake and shifts it out on a single line, framed as start, 7 data bits LSB first, even parity, stop.
- Sits between a parallel producer and the serial line in the SDM sequential subsystem.

Parameters:
- DATA_W, 7, payload width; fixed at 7 for this block (parity and counter widths derive from it).
- BIT_CYCLES, 4, clock cycles each serial bit is held on tx; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- d  input  7  parallel word to transmit; sampled only on an accepted load.
- load  input  1  producer valid; a word is accepted at a rising edge where load=1 and ready=1.
- ready  output  1  high only in IDLE; block can accept a word.
- tx  output  1  serial line, idle-high, registered.
- busy  output  1  high from the accepting edge until the frame completes.
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset is synchronous and active-high: at a rising edge with reset=1, state=IDLE, tx=1, busy=0, done=0, ready=1, shift register=0, counters=0. Reset has priority over load and over any frame in progress; a frame aborted mid-way is discarded, and tx returns to 1 at that edge.
- All outputs are registered, or decoded from the state register only; there is no combinational path from d or load to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1, busy=0. On load=1, at the next edge: latch d into the shift register, compute parity as the XOR of d (even parity), go to START, and set tx=0, busy=1, ready=0.
- Bit timing: a cycle counter runs 0..BIT_CYCLES-1. The state or bit advances on the edge where the counter equals BIT_CYCLES-1, so each bit is held exactly BIT_CYCLES cycles.
- START: tx=0, then go to DATA.
- DATA: tx = shift register bit 0. At each bit boundary, shift right and increment the bit index. After index 6 completes, go to PARITY.
- PARITY: tx = latched parity bit, then go to STOP.
- STOP: tx=1. At its final boundary, go to IDLE with busy=0, ready=1, done=1.
- done is high for exactly one cycle: the first IDLE cycle. It clears on the next edge regardless of load.
- Latency and throughput:
  - A frame is 10*BIT_CYCLES cycles from the accepting edge E0 to the edge that returns the block to IDLE, E(10*BIT_CYCLES).
  - With load held high, the next word is accepted at the first IDLE edge, so words go back to back with one idle-high cycle between frames.
- load while busy (ready=0) is ignored; d changes while busy do not affect the frame in flight.
- load=1 together with reset=1: reset wins and no word is accepted.
- d = 7'b0000000 gives parity 0; d = 7'b1111111 gives parity 1. Both are legal.

Test Plan:
- Reset: hold reset=1 for 2 cycles with load=1 and d=7'b0101010 -> tx=1, ready=1, busy=0, done=0; no frame starts.
- Single frame (BIT_CYCLES=4): d=7'b0101010, load pulsed for 1 cycle at E0 -> over 40 cycles tx carries, 4 cycles per bit, 0 | 0,1,0,1,0,1,0 | 1 (parity) | 1 (stop). Then ready=1 and done=1 for exactly 1 cycle after E40.
- Ignored load: during the frame above, pulse load with d=7'b1111111 at cycle 12 -> tx sequence unchanged; no second frame.
- Back-to-back: load held at 1, d=7'b1111111 then 7'b0000001 -> frame 1 data all 1s, parity 1; one idle-high cycle; frame 2 data 1,0,0,0,0,0,0, parity 1; done pulses once per frame.
- Mid-frame reset: assert reset at cycle 18 of a frame -> at that edge tx=1, ready=1, busy=0, no done pulse. A new load after reset transmits a complete, correct frame.
- BIT_CYCLES=1 build: d=7'b1000000 -> 10-cycle frame 0,0,0,0,0,0,0,1,1,1; ready again after E10.

Source files
------------

// File: rtl/sdm_serial_tx7.sv
// Parallel-to-serial transmitter: start bit, 7 data bits LSB first, even parity, stop bit.
// Each serial bit is held on tx for BIT_CYCLES clocks; one word accepted per valid/ready handshake.
module sdm_serial_tx7 #(
   parameter int DATA_W     = 7,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [7:0]       CNT_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state_reg, state_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic [IDX_W-1:0]  bit_reg, bit_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic              par_reg, par_next;
   logic              tx_reg, tx_next;
   logic              done_reg, done_next;
   logic              bit_end;

   // Running XOR across the incoming word; the last stage is the even-parity bit.
   logic [DATA_W-1:0] par_chain;
   assign par_chain[0] = d[0];
   genvar gi;
   generate
      for (gi = 1; gi < DATA_W; gi++) begin : g_par
         assign par_chain[gi] = par_chain[gi-1] ^ d[gi];
      end
   endgenerate

   assign bit_end = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         tx_reg    <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         tx_reg    <= tx_next;
         done_reg  <= done_next;
      end
   end

   // tx_next is the value of the bit that the next state will present, so tx stays registered.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      tx_next    = tx_reg;
      done_next  = 1'b0;

      if (state_reg != IDLE) begin
         cnt_next = bit_end ? 8'd0 : cnt_reg + 8'd1;
      end

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (load) begin
               shift_next = d;
               par_next   = par_chain[DATA_W-1];
               cnt_next   = '0;
               bit_next   = '0;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_next = shift_reg >> 1;
               if (bit_reg == BIT_LAST) begin
                  tx_next    = par_reg;
                  state_next = PARITY;
               end else begin
                  bit_next = bit_reg + 1'b1;
                  tx_next  = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign tx    = tx_reg;
   assign done  = done_reg;
   assign ready = (state_reg == IDLE);
   assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_sdm_serial_tx7.sv
// Randomised and directed bench for sdm_serial_tx7 against a frame-position reference model.
// A second instance built with BIT_CYCLES=1 covers the single-cycle bit timing.
module tb_sdm_serial_tx7;

   localparam int BC    = 4;
   localparam int FRAME = 10 * BC;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] d = '0;
   logic       load = 1'b0;
   logic       ready, tx, busy, done;

   logic [6:0] d1 = '0;
   logic       load1 = 1'b0;
   logic       ready1, tx1, busy1, done1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: whether a frame is in flight, cycles since acceptance, and the word.
   bit         m_active = 1'b0;
   int         m_k = 0;
   logic [6:0] m_word = '0;
   bit         m_done = 1'b0;

   always #5 clk = ~clk;

   sdm_serial_tx7 #(.DATA_W(7), .BIT_CYCLES(BC)) dut (
      .clk(clk), .reset(reset), .d(d), .load(load),
      .ready(ready), .tx(tx), .busy(busy), .done(done)
   );

   sdm_serial_tx7 #(.DATA_W(7), .BIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .d(d1), .load(load1),
      .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
   );

   function automatic logic frame_bit(input logic [6:0] w, input int i);
      if (i == 0) return 1'b0;
      if (i <= 7) return w[i-1];
      if (i == 8) return ^w;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_k      = 0;
      end else if (m_active) begin
         m_k++;
         if (m_k == FRAME) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (load) begin
            m_active = 1'b1;
            m_k      = 0;
            m_word   = d;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx",    {31'd0, tx},    {31'd0, m_active ? frame_bit(m_word, m_k / BC) : 1'b1});
         check("ready", {31'd0, ready}, {31'd0, !m_active});
         check("busy",  {31'd0, busy},  {31'd0, m_active});
         check("done",  {31'd0, done},  {31'd0, m_done});
      end
   end

   initial begin
      logic [9:0] exp_a;
      logic [9:0] exp_b;
      logic [9:0] got;
      int         ndone;
      int         budget;

      exp_a = 10'b1101010100;   // frame for 7'b0101010, bit 0 is the start bit
      exp_b = 10'b1110000000;   // frame for 7'b1000000

      // Reset held two cycles with a pending word: nothing must start.
      load = 1'b1;
      d    = 7'b0101010;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      load  = 1'b0;
      @(negedge clk);
      check("rst_tx",    {31'd0, tx},    32'd1);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_done",  {31'd0, done},  32'd0);

      // Single frame with an ignored load pulse at cycle 12.
      @(posedge clk);
      #1;
      load = 1'b1;
      d    = 7'b0101010;
      @(posedge clk);
      #1;
      load = 1'b0;
      got  = '0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         if (k % BC == BC / 2) got[k / BC] = tx;
         if (k == 12) begin
            load = 1'b1;
            d    = 7'b1111111;
         end
         if (k == 13) load = 1'b0;
      end
      check("frame_a_bits", {22'd0, got}, {22'd0, exp_a});
      @(negedge clk);
      check("frame_a_done",  {31'd0, done},  32'd1);
      check("frame_a_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      check("frame_a_done_clr", {31'd0, done}, 32'd0);
      check("frame_a_no_second", {31'd0, busy}, 32'd0);

      // Back-to-back with load held high.
      @(posedge clk);
      #1;
      load = 1'b1;
      d    = 7'b1111111;
      @(posedge clk);
      #1;
      d     = 7'b0000001;
      ndone = 0;
      budget = 0;
      while (ndone < 2 && budget < 2 * FRAME + 10) begin
         @(negedge clk);
         budget++;
         if (done) ndone++;
         if (ndone == 2) load = 1'b0;
      end
      check("b2b_done_count", ndone, 32'd2);
      repeat (3) @(posedge clk);
      #1;

      // Mid-frame reset at cycle 18, then a fresh frame.
      load = 1'b1;
      d    = 7'($urandom);
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_tx",    {31'd0, tx},    32'd1);
      check("midrst_ready", {31'd0, ready}, 32'd1);
      check("midrst_busy",  {31'd0, busy},  32'd0);
      check("midrst_done",  {31'd0, done},  32'd0);
      @(posedge clk);
      #1;
      load = 1'b1;
      d    = 7'b1011001;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (FRAME + 3) @(posedge clk);
      #1;

      // BIT_CYCLES=1 instance.
      load1 = 1'b1;
      d1    = 7'b1000000;
      @(posedge clk);
      #1;
      load1 = 1'b0;
      got   = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         got[k] = tx1;
      end
      check("bc1_bits", {22'd0, got}, {22'd0, exp_b});
      @(negedge clk);
      check("bc1_ready", {31'd0, ready1}, 32'd1);
      check("bc1_done",  {31'd0, done1},  32'd1);
      check("bc1_busy",  {31'd0, busy1},  32'd0);

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 299) == 0);
         load  = ($urandom_range(0, 3) != 0);
         d     = 7'($urandom);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      load  = 1'b0;
      repeat (FRAME + 5) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
